// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - RV32M-style multiply/divide execute unit.
// Iterative shift-add multiply (or single-cycle when MUL_FAST), restoring divide.
module execute_muldiv #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 6,
   parameter bit MUL_FAST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag_out,
   output logic             busy
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                neg_q, neg_d, nrem_q, nrem_d;
   logic [XLEN-1:0]     mb_q, mb_d, res_q, res_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                accept, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf, last_iter;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic [2*XLEN-1:0]   fast_prod, mul_next, div_next, step_next;
   logic [XLEN:0]       mul_sum, rem_sh, rem_diff;

   // Apply the latched signs to a raw magnitude accumulator and pick the requested half.
   function automatic logic [XLEN-1:0] fix_result(input logic [2:0] o, input logic [2*XLEN-1:0] acc,
                                                  input logic nq, input logic nr);
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   r;
      p = '0;
      r = '0;
      if (!o[2]) begin
         p = nq ? -acc : acc;
         r = (o[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
      end else if (o[1]) begin
         r = nr ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      end else begin
         r = nq ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      end
      return r;
   endfunction

   assign accept    = in_valid && in_ready;
   assign sgn_a     = op[2] ? ~op[0] : (op != 3'd3);
   assign sgn_b     = op[2] ? ~op[0] : (op == 3'd0 || op == 3'd1);
   assign neg_a     = sgn_a && a[XLEN-1];
   assign neg_b     = sgn_b && b[XLEN-1];
   assign mag_a     = neg_a ? -a : a;
   assign mag_b     = neg_b ? -b : b;
   assign div_zero  = op[2] && (b == '0);
   assign div_ovf   = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
   assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
   assign last_iter = (cnt_q == CW'(1));

   // Multiply: add multiplicand into the top half when the low bit is set, then shift right.
   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
   assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
   // Divide: shift {rem, dividend} left; keep the trial subtraction only if it did not borrow.
   assign rem_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign rem_diff  = rem_sh - {1'b0, mb_q};
   assign div_next  = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   assign step_next = (state_q == S_MUL) ? mul_next : div_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) begin
            if (op[2])         state_d = (div_zero || div_ovf) ? S_DONE : S_DIV;
            else               state_d = MUL_FAST ? S_DONE : S_MUL;
         end
         S_MUL, S_DIV: if (last_iter) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE) && !flush;
      out_valid = (state_q == S_DONE) && !flush;
      busy      = (state_q != S_IDLE);
      result    = out_valid ? res_q : '0;
      tag_out   = out_valid ? tag_q : '0;
   end

   always_comb begin
      op_d   = op_q;
      tag_d  = tag_q;
      neg_d  = neg_q;
      nrem_d = nrem_q;
      mb_d   = mb_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      res_d  = res_q;
      if (accept) begin
         op_d   = op;
         tag_d  = tag_in;
         neg_d  = neg_a ^ neg_b;
         nrem_d = neg_a;
         mb_d   = mag_b;
         acc_d  = {{XLEN{1'b0}}, mag_a};
         cnt_d  = CNT_LOAD;
         if (div_zero)      res_d = op[1] ? a : '1;
         else if (div_ovf)  res_d = op[1] ? '0 : a;
         else if (!op[2])   res_d = fix_result(op, fast_prod, neg_a ^ neg_b, neg_a);
         else               res_d = '0;
      end else if (state_q == S_MUL || state_q == S_DIV) begin
         acc_d = step_next;
         cnt_d = cnt_q - CW'(1);
         if (last_iter) res_d = fix_result(op_q, step_next, neg_q, nrem_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         tag_q  <= '0;
         neg_q  <= 1'b0;
         nrem_q <= 1'b0;
         mb_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         res_q  <= '0;
      end else begin
         op_q   <= op_d;
         tag_q  <= tag_d;
         neg_q  <= neg_d;
         nrem_q <= nrem_d;
         mb_q   <= mb_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         res_q  <= res_d;
      end
   end
endmodule

// File: tb/tb_execute_muldiv.sv
// tb/tb_execute_muldiv.sv - scoreboard bench for execute_muldiv.
module tb_execute_muldiv;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic [5:0]  tag_in = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   logic [5:0]  tag_out;
   logic        in_valid_f = 1'b0, out_ready_f = 1'b1;
   logic        in_ready_f, out_valid_f, busy_f;
   logic [31:0] result_f;
   logic [5:0]  tag_out_f;

   int total = 0, bad = 0, cyc = 0;
   logic prev_v = 1'b0;

   typedef struct {
      logic [31:0] res;
      logic [5:0]  tag;
      int          lat;
      int          acc;
   } exp_t;
   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   execute_muldiv #(.XLEN(32), .TAG_W(6), .MUL_FAST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .tag_in(tag_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .tag_out(tag_out), .busy(busy));

   execute_muldiv #(.XLEN(32), .TAG_W(6), .MUL_FAST(1'b1)) dut_f (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_ready(in_ready_f), .op(op), .a(a), .b(b),
      .tag_in(tag_in), .flush(flush), .out_valid(out_valid_f), .out_ready(out_ready_f),
      .result(result_f), .tag_out(tag_out_f), .busy(busy_f));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid && !prev_v) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            chk("result", 64'(result), 64'(e.res));
            chk("tag_out", 64'(tag_out), 64'(e.tag));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
      prev_v <= out_valid;
   end

   task automatic drive(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [5:0] t, input logic [31:0] er, input int el, input bit push);
      op = o; a = aa; b = bb; tag_in = t; in_valid = 1'b1;
      if (push) q.push_back('{er, t, el, cyc});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [5:0] t, input logic [31:0] er, input int el, input bit push);
      int w = 0;
      while (!in_ready && w < 200) begin @(negedge clk); w++; end
      if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      drive(o, aa, bb, t, er, el, push);
   endtask

   task automatic drain();
      int w = 0;
      while ((q.size() != 0 || busy) && w < 200) begin @(negedge clk); w++; end
      if (q.size() != 0 || busy) chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_tag_out", 64'(tag_out), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      drive(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 6'd5, 32'hFFFF_FFFE, 33, 1'b1);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 32'hFFFF_FFFE, 33, 1'b1);
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'h0000_0000, 33, 1'b1);
      issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 6'd3, 32'hFFFF_FFFF, 33, 1'b1);
      issue(3'd0, 32'h0000_1000, 32'h0001_0000, 6'd4, 32'h1000_0000, 33, 1'b1);
      issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 6'd10, 32'hFFFF_FFFD, 33, 1'b1);
      issue(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 6'd11, 32'hFFFF_FFFF, 33, 1'b1);
      issue(3'd5, 32'h0000_0007, 32'h0000_0000, 6'd12, 32'hFFFF_FFFF, 1, 1'b1);
      issue(3'd7, 32'h0000_0007, 32'h0000_0000, 6'd13, 32'h0000_0007, 1, 1'b1);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14, 32'h0000_0000, 1, 1'b1);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 32'h8000_0000, 1, 1'b1);
      issue(3'd5, 32'd100, 32'd7, 6'd16, 32'd14, 33, 1'b1);
      issue(3'd7, 32'd100, 32'd7, 6'd17, 32'd2, 33, 1'b1);
      drain();

      // Backpressure: hold the result for ten cycles.
      out_ready = 1'b0;
      issue(3'd0, 32'd3, 32'd5, 6'd9, 32'd15, 33, 1'b1);
      begin
         int w = 0;
         while (!out_valid && w < 100) begin @(negedge clk); w++; end
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold", {result, 26'd0, tag_out}, {32'd15, 26'd0, 6'd9});
         chk("bp_flags", {62'd0, in_ready, busy}, 64'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_consumed", {62'd0, out_valid, in_ready}, 64'd1);

      // Flush twelve cycles into a divide, then flush with a simultaneous offer.
      issue(3'd4, 32'd100, 32'd7, 6'd3, 32'd0, 0, 1'b0);
      repeat (11) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_gate", {62'd0, in_ready, out_valid}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_idle", 64'(busy), 64'd0);
      @(negedge clk);
      flush = 1'b1;
      op = 3'd0; a = 32'd2; b = 32'd2; tag_in = 6'd20; in_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_no_accept", 64'(busy), 64'd0);
      @(negedge clk);
      issue(3'd5, 32'd100, 32'd7, 6'd12, 32'd14, 33, 1'b1);
      drain();

      // Reset mid-multiply.
      issue(3'd0, 32'd6, 32'd7, 6'd21, 32'd0, 0, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mul", {61'd0, busy, out_valid, 1'b0}, 64'd0);
      chk("rst_mid_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_stale_after_rst", 64'(busy), 64'd0);

      // Reset while a result is held in DONE.
      out_ready = 1'b0;
      issue(3'd5, 32'd7, 32'd0, 6'd7, 32'hFFFF_FFFF, 1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_done_outputs", {result, 26'd0, tag_out}, 64'd0);
      chk("rst_done_flags", {62'd0, out_valid, busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_done_idle", 64'(busy), 64'd0);

      // Single-cycle multiply variant.
      op = 3'd0; a = 32'hFFFF_FFFF; b = 32'h0000_0002; tag_in = 6'd5; in_valid_f = 1'b1;
      #0;
      chk("fast_ready", 64'(in_ready_f), 64'd1);
      @(negedge clk);
      in_valid_f = 1'b0;
      chk("fast_valid", 64'(out_valid_f), 64'd1);
      chk("fast_result", {result_f, 26'd0, tag_out_f}, {32'hFFFF_FFFE, 26'd0, 6'd5});
      @(negedge clk);
      chk("fast_idle", {62'd0, out_valid_f, busy_f}, 64'd0);
      chk("queue_empty", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter TAG_W, default 6, width of destination physical-register tag.
REQ-003 SHALL have parameter MUL_FAST, default 0; 1 = single-cycle registered multiply, 0 = iterative shift-add multiply.
REQ-004 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  in  1  operation offered.
REQ-007 SHALL have port in_ready  out  1  unit can accept an operation.
REQ-008 SHALL have port op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have ports a, b  in  XLEN each  forwarded rs1/rs2 operand values.
REQ-010 SHALL have port tag_in  in  TAG_W  destination physical register.
REQ-011 SHALL have port flush  in  1  squash in-flight operation (branch/jump redirect).
REQ-012 SHALL have port out_valid  out  1  result available.
REQ-013 SHALL have port out_ready  in  1  consumer accepts result.
REQ-014 SHALL have ports result  out  XLEN  and  tag_out  out  TAG_W.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE (drives pipeline stall).

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-017 in_ready SHALL equal (state==IDLE) && !flush; accept occurs on an edge with in_valid && in_ready.
REQ-018 On accept, SHALL latch op, tag_in, operand magnitudes and result sign; next state MUL for op 0-3, DIV for op 4-7.
REQ-019 Signedness: MUL/MULH/DIV/REM both operands signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned.
REQ-020 MUL state SHALL run exactly XLEN iterations (one bit per cycle, 2*XLEN accumulator), then go to DONE; accept-to-out_valid latency = XLEN+1 cycles.
REQ-021 If MUL_FAST=1, mul ops SHALL go IDLE->DONE directly; latency = 1 cycle.
REQ-022 DIV state SHALL perform restoring division, XLEN iterations, then DONE; latency = XLEN+1 cycles.
REQ-023 Result selection: MUL = low XLEN bits of product; MULH* = high XLEN bits; DIV* = quotient; REM* = remainder; sign fix applied once when entering DONE.
REQ-024 Divide-by-zero SHALL bypass iteration (IDLE->DONE, latency 1): quotient = all ones, remainder = a.
REQ-025 Signed overflow (DIV/REM, a = most-negative, b = -1) SHALL bypass iteration (latency 1): quotient = a, remainder = 0.
REQ-026 In DONE, out_valid=1; result and tag_out SHALL hold stable until out_ready=1; the DONE->IDLE transition occurs on that edge.
REQ-027 A new operation SHALL NOT be accepted in the cycle its predecessor is consumed; earliest next accept is the following cycle.
REQ-028 flush=1 in any state SHALL force state to IDLE at the next edge, discard the operation, and gate out_valid to 0 combinationally.
REQ-029 flush and in_valid asserted together SHALL NOT accept (in_ready low per REQ-017).
REQ-030 Iteration counter SHALL be clog2(XLEN)+1 bits wide and SHALL be reloaded on every accept; no wrap-around carries between operations.
REQ-031 result and tag_out SHALL be 0 whenever out_valid=0.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, counter 0, accumulators 0; outputs: in_ready=1 (when rst_n high again and flush low), out_valid=0, busy=0, result=0, tag_out=0.
REQ-033 Reset asserted mid-operation SHALL abort it; no result shall appear after reset deassertion.
REQ-034 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (XLEN=32, MUL_FAST=0)
REQ-035 MUL a=0xFFFFFFFF, b=0x00000002, tag 5 -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFE, tag_out=5.
REQ-036 MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF.
REQ-037 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=7, b=0 -> 0xFFFFFFFF after 1 cycle; REM a=0x80000000, b=0xFFFFFFFF -> 0 after 1 cycle.
REQ-038 Backpressure: out_ready low for 10 cycles after out_valid -> result/tag_out stable, in_ready=0, busy=1 throughout; consumed on first out_ready-high edge; in_ready=1 the next cycle.
REQ-039 flush asserted 12 cycles into a DIV -> out_valid never asserts, state IDLE next cycle, next op completes correctly with its own tag.
REQ-040 rst_n pulsed low mid-MUL and during DONE -> outputs reach reset values immediately (no clock), no stale result afterwards; repeat REQ-035 with MUL_FAST=1 -> latency 1.
